// File: rtl/fetch_vector_control.sv
// fetch_vector_control: reset-vector and prioritised interrupt-vector fetch sequencer; define FETCH_NMI_EN to make line 0 non-maskable
module fetch_vector_control #(
  parameter int NUM_INT = 4,
  parameter int SRC_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               flush,
  input  logic [NUM_INT-1:0] int_req,
  input  logic [NUM_INT-1:0] int_mask,
  output logic               extend,
  output logic               fetch,
  output logic [SRC_W-1:0]   fetch_src,
  output logic [NUM_INT-1:0] int_ack,
  output logic [NUM_INT-1:0] int_pend
);
  localparam int SEL_W = NUM_INT > 1 ? $clog2(NUM_INT) : 1;
  typedef enum logic [1:0] {STRT, RST, NORM, INT} state_t;
  state_t state, state_nxt;
  logic [NUM_INT-1:0] pend, req_q, mask, elig, pick;
  logic [SEL_W-1:0] sel, win;
  logic any, load, svc;
`ifdef FETCH_NMI_EN
  assign mask = int_mask & ~NUM_INT'(1);
`else
  assign mask = int_mask;
`endif
  assign elig = pend & ~mask;
  // the line being acknowledged must not re-win the back-to-back selection
  assign pick = state == INT ? elig & ~(NUM_INT'(1) << sel) : elig;
  assign any = |pick;
  assign svc = state == INT && valid;
  always_comb begin
    win = '0;
    for (int i = NUM_INT - 1; i >= 0; i--)
      if (pick[i]) win = SEL_W'(i);
  end
  always_comb begin
    state_nxt = state == STRT ? RST :
                state == NORM ? (any && !flush ? INT : NORM) :
                valid         ? (any ? INT : NORM) : state;
    load      = state_nxt == INT && (state != INT || valid);
    extend    = valid && (state == RST || state == INT);
    fetch     = extend;
    fetch_src = svc ? SRC_W'(sel) + SRC_W'(1) : '0;
    int_ack   = svc ? NUM_INT'(1) << sel : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STRT;
      pend  <= '0;
      req_q <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      req_q <= int_req;
      pend  <= (pend & ~int_ack) | (int_req & ~req_q);
      if (load) sel <= win;
    end
  end
  assign int_pend = pend;
endmodule

// File: tb/tb_fetch_vector_control.sv
// tb_fetch_vector_control: random and directed stimulus against a cycle-level behavioural model
module tb_fetch_vector_control;
  localparam int N = 4;
  localparam int SW = 3;
  logic clk = 0, rst = 1, valid = 0, flush = 0;
  logic [N-1:0] int_req = '0, int_mask = '0, int_ack, int_pend;
  logic extend, fetch;
  logic [SW-1:0] fetch_src;
  int checks = 0, passes = 0;
  int phase, svc;
  bit [N-1:0] m_pend, m_prev;

  fetch_vector_control #(.NUM_INT(N), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .int_req(int_req), .int_mask(int_mask),
    .extend(extend), .fetch(fetch), .fetch_src(fetch_src), .int_ack(int_ack), .int_pend(int_pend));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int lowest(input bit [N-1:0] e);
    for (int i = 0; i < N; i++) if (e[i]) return i;
    return -1;
  endfunction

  task automatic do_reset;
    #3 rst = 1;
    #1;
    check("rst_fetch", 32'(fetch), 0);
    check("rst_extend", 32'(extend), 0);
    check("rst_src", 32'(fetch_src), 0);
    check("rst_ack", 32'(int_ack), 0);
    check("rst_pend", 32'(int_pend), 0);
    phase = 0; svc = -1; m_pend = '0; m_prev = '0;
    @(negedge clk) rst = 0;
  endtask

  // called at a negedge; returns at the next negedge
  task automatic cyc(input bit v, input bit f, input bit [N-1:0] req, input bit [N-1:0] msk);
    bit go, vec;
    bit [N-1:0] rise, m, elig;
    int old;
    valid = v; flush = f; int_req = req; int_mask = msk;
    vec = v && svc >= 0;
    go  = v && (phase == 1 || vec);
    #1;
    check("fetch", 32'(fetch), 32'(go));
    check("extend", 32'(extend), 32'(go));
    check("src", 32'(fetch_src), vec ? 32'(svc + 1) : 0);
    check("ack", 32'(int_ack), vec ? 32'(1) << svc : 0);
    check("pend", 32'(int_pend), 32'(m_pend));
    @(posedge clk);
    rise = req & ~m_prev;
    m = msk;
`ifdef FETCH_NMI_EN
    m[0] = 1'b0;
`endif
    elig = m_pend & ~m;
    if (phase == 0) phase = 1;
    else if (phase == 1) begin
      if (v) begin phase = 2; svc = lowest(elig); end
    end else if (svc >= 0) begin
      if (v) begin old = svc; m_pend[old] = 1'b0; elig[old] = 1'b0; svc = lowest(elig); end
    end else if (!f) svc = lowest(elig);
    m_pend |= rise;
    m_prev = req;
    @(negedge clk);
  endtask

  initial begin
    bit [N-1:0] rq, mk;
    @(negedge clk);
    do_reset;
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 0, 4'b0100, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 0, 4'b1010, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 4'b0001, 4'b0001);
    repeat (3) cyc(1, 0, 0, 4'b0001);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 4'b0010, 0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 4'b1010, 0);
    repeat (3) cyc(0, 0, 0, 0);
    do_reset;
    cyc(1, 0, 4'b0100, 0);
    repeat (5) cyc(1, 0, 4'b0100, 0);
    rq = '0; mk = '0;
    for (int k = 0; k < 600; k++) begin
      rq ^= N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mk = N'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rq, mk);
      if (k % 150 == 149) do_reset;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_vector_control.md
# fetch_vector_control

Parametrised fetch-stage controller that sequences the reset-vector fetch after reset and arbitrates up to NUM_INT edge-triggered interrupt lines into vector fetches. It sits beside the fetch unit and PC mux. It drives `extend`/`fetch` to insert a vector fetch and `fetch_src` to select the vector. Interrupts are latched per line, masked, prioritised, acknowledged and serviced back-to-back; the single `int` input of the previous generation is replaced by this multi-line scheme.

## Interface
- `NUM_INT`, 4, number of interrupt lines (1..15)
- `SRC_W`, 3, width of `fetch_src`; must satisfy 2^SRC_W >= NUM_INT+1
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high
- `valid`  input  1  fetch stage can accept/issue this cycle
- `flush`  input  1  pipeline flush in progress
- `int_req`  input  NUM_INT  interrupt request lines, rising-edge sensitive
- `int_mask`  input  NUM_INT  1 = line masked (pending kept, not serviced)
- `extend`  output  1  extend current fetch (vector fetch in progress)
- `fetch`  output  1  issue vector fetch this cycle
- `fetch_src`  output  SRC_W  vector select: 0 = reset, i+1 = interrupt line i
- `int_ack`  output  NUM_INT  one-hot, 1-cycle pulse when line's vector fetch issues
- `int_pend`  output  NUM_INT  current pending register

## Operation
- Registers: `state` (STRT, RST, NORM, INT), `pend[NUM_INT]`, `req_q[NUM_INT]`, `sel` (log2 NUM_INT bits).
- Edge detect: `req_q <= int_req` each cycle; rise = `int_req & ~req_q`; rise sets `pend` bit.
- Eligible = `pend & ~int_mask`; winner = lowest-index eligible bit.
- State transitions (evaluated each cycle):
  - STRT -> RST unconditionally.
  - RST -> stays until `valid`; on `valid`: INT if any eligible, else NORM.
  - NORM -> INT if any eligible and `flush`=0; else NORM. `flush`=1 defers entry only.
  - INT -> stays until `valid`; on `valid`: INT if another eligible remains (excluding the line being acked), else NORM.
- `sel` loads the winner on every transition into INT (including INT->INT); it is frozen while in INT. A higher-priority arrival waits for the next selection.
- Outputs (combinational from `state`, `valid`, `sel`):
  - `state`=RST and `valid`: `extend`=1, `fetch`=1, `fetch_src`=0.
  - `state`=INT and `valid`: `extend`=1, `fetch`=1, `fetch_src`=`sel`+1, `int_ack[sel]`=1.
  - Otherwise: `extend`, `fetch`, `fetch_src` and `int_ack` are all 0.
- Pending clear: `int_ack[i]` clears `pend[i]` at the same edge; a simultaneous new rise on line i wins and `pend[i]` stays 1.
- Masking a line while in INT with that line selected does not abort the service; the fetch completes.
- `flush` has no effect in RST or INT; vector fetches are never cancelled.

## Timing
- Reset (async assert): `state`=STRT, `pend`=0, `req_q`=0, `sel`=0. All outputs are 0 while reset is asserted and in STRT.
- First edge after reset release: RST. Reset vector issues in the first cycle where `state`=RST and `valid`=1.
- A line held high through reset release registers as a rise on the first edge (`req_q` resets to 0).
- Latency in NORM with `valid`=1: rise sampled at edge k sets `pend` after k; state goes INT after edge k+1; `fetch`/`int_ack` are asserted in the cycle after edge k+1 (2 cycles).
- Back-to-back: with two lines pending, vector fetches occur on consecutive `valid` cycles without a NORM cycle in between.
- Reset asserted mid-service: immediate return to STRT, pending is lost, and the sequence restarts at RST.

## Configuration
- `FETCH_NMI_EN` defined: line 0 is non-maskable; `int_mask[0]` is ignored. Line 0 still wins priority and is still deferred by `flush` in NORM.
- `FETCH_NMI_EN` undefined: all lines maskable, identical rules.

## Test plan
- Reset, then `valid`=1 from the first cycle -> one cycle `fetch`=1, `extend`=1, `fetch_src`=0, then NORM with outputs 0.
- NORM, pulse `int_req[2]` for 1 cycle -> 2 cycles later `fetch`=1, `fetch_src`=3, `int_ack`=4'b0100; `int_pend` returns to 0.
- Rise on lines 1 and 3 in the same cycle -> `fetch_src`=2 then `fetch_src`=4 on consecutive `valid` cycles; no NORM cycle between them.
- Pulse `int_req[0]` with `int_mask[0]`=1 -> `int_pend`=4'b0001 and no fetch. Clear the mask -> fetch with `fetch_src`=1. With `FETCH_NMI_EN`, the fetch occurs despite the mask.
- Pending line 1 while `flush`=1 for 3 cycles -> no fetch during the flush; INT entered on the edge after `flush` drops. Holding `valid`=0 in INT -> the state holds and `int_ack` stays 0.
- Assert `rst` while in INT with `pend`=4'b1010 -> `pend`=0, outputs 0; after release the RST vector is fetched first.
